// File: rtl/moving_average_filter.sv
// Multi-channel boxcar filter: each channel keeps a circular window of 2^LOG2_DEPTH samples and a running sum.
// Optional round-half-up with clamping when MAF_ROUND_EN is defined; truncation otherwise.
module moving_average_filter #(
   parameter int DATA_W     = 24,
   parameter int LOG2_DEPTH = 3,
   parameter int CHANNELS   = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         in_valid,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   output logic                         out_valid,
   output logic [CHANNELS*DATA_W-1:0]   out_data,
   output logic                         primed
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
`ifdef MAF_ROUND_EN
   localparam int ACC_W = DATA_W + LOG2_DEPTH + 1;
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_DEPTH - 1);
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`else
   localparam int ACC_W = DATA_W + LOG2_DEPTH;
`endif
   localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);

   logic [DATA_W-1:0]              mem_q [CHANNELS][DEPTH];
   logic signed [ACC_W-1:0]        acc_q [CHANNELS];
   logic signed [ACC_W-1:0]        acc_d [CHANNELS];
   logic [DATA_W-1:0]              oldest [CHANNELS];
   logic [LOG2_DEPTH-1:0]          wr_ptr_q, wr_ptr_d;
   logic [LOG2_DEPTH:0]            fill_q, fill_d;
   logic                           out_valid_q, out_valid_d;
   logic [CHANNELS*DATA_W-1:0]     out_data_q, out_data_d;
   logic                           primed_q, primed_d;
   logic                           accept;

   function automatic logic [DATA_W-1:0] mean_f(input logic signed [ACC_W-1:0] a);
`ifdef MAF_ROUND_EN
      logic signed [ACC_W-1:0] r;
      r = (a + HALF) >>> LOG2_DEPTH;
      if (r > MAXV)      mean_f = MAXV[DATA_W-1:0];
      else if (r < MINV) mean_f = MINV[DATA_W-1:0];
      else               mean_f = r[DATA_W-1:0];
`else
      mean_f = DATA_W'(a >>> LOG2_DEPTH);
`endif
   endfunction

   assign accept = in_valid & ~reset & ~clear;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      primed_d    = primed_q;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         // Slots not yet written since reset/clear contribute zero, so memory needs no flush.
         oldest[c] = (fill_q == FULL) ? mem_q[c][wr_ptr_q] : '0;
         acc_d[c]  = acc_q[c];
      end
      if (accept) begin
         wr_ptr_d    = wr_ptr_q + LOG2_DEPTH'(1);
         if (fill_q != FULL) fill_d = fill_q + (LOG2_DEPTH+1)'(1);
         out_valid_d = 1'b1;
         primed_d    = (fill_d == FULL);
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            acc_d[c] = acc_q[c] + ACC_W'($signed(in_data[c*DATA_W +: DATA_W]))
                                - ACC_W'($signed(oldest[c]));
            out_data_d[c*DATA_W +: DATA_W] = mean_f(acc_d[c]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         primed_q    <= 1'b0;
         for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         primed_q    <= primed_d;
         for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned c = 0; c < CHANNELS; c++)
            mem_q[c][wr_ptr_q] <= in_data[c*DATA_W +: DATA_W];
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign primed    = primed_q;

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench for moving_average_filter (DATA_W=24, LOG2_DEPTH=3, CHANNELS=2).
// Expectations for the rounding cases follow MAF_ROUND_EN when it is defined.
module tb_moving_average_filter;

   typedef struct packed {
      logic [47:0] data;
      logic        primed;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, clear, in_valid;
   logic [47:0] in_data;
   logic        out_valid;
   logic [47:0] out_data;
   logic        primed;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        mon_en = 1'b0;
   logic [47:0] mon_last = '0;

   moving_average_filter #(.DATA_W(24), .LOG2_DEPTH(3), .CHANNELS(2)) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data), .primed(primed)
   );

   always #5 clk = ~clk;

   // Monitor: pops on every valid output, otherwise checks that out_data holds.
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output got data=%h primed=%b, required no output", out_data, primed);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (out_data !== e.data || primed !== e.primed) begin
                  errors++;
                  $display("FAIL output got data=%h primed=%b, required data=%h primed=%b",
                           out_data, primed, e.data, e.primed);
               end
            end
            mon_last = out_data;
         end else begin
            checks++;
            if (out_data !== mon_last) begin
               errors++;
               $display("FAIL hold got data=%h, required %h", out_data, mon_last);
            end
         end
      end
   end

   task automatic check(input string name, input logic [47:0] got, input logic [47:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %h, required %h", name, got, req);
      end
   endtask

   task automatic send(input logic [23:0] c0, input logic [23:0] c1,
                       input logic [23:0] e0, input logic [23:0] e1, input logic ep);
      exp_t e;
      e.data   = {e1, e0};
      e.primed = ep;
      exp_q.push_back(e);
      in_valid = 1'b1;
      in_data  = {c1, c0};
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Clear, optionally with a sample that must be discarded.
   task automatic do_clear(input logic with_sample, input logic [23:0] c0);
      clear    = 1'b1;
      in_valid = with_sample;
      in_data  = {24'd0, c0};
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      mon_last = '0;
      check("clear_out_valid", {47'd0, out_valid}, 48'd0);
      check("clear_out_data", out_data, 48'd0);
      check("clear_primed", {47'd0, primed}, 48'd0);
   endtask

   int ramp[9]  = '{8, -16, 24, -32, 40, -48, 56, -64, 72};
   int rexp[9]  = '{1, -1, 2, -2, 3, -3, 4, -4, 4};
   int r1exp[9] = '{100, 200, 300, 400, 500, 600, 700, 800, 800};
`ifdef MAF_ROUND_EN
   logic [23:0] xpos[10] = '{24'h100000, 24'h200000, 24'h300000, 24'h400000, 24'h4FFFFF,
                             24'h5FFFFF, 24'h6FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
   logic [23:0] xneg[10] = '{24'h5FFFFF, 24'h3FFFFF, 24'h1FFFFF, 24'h000000, 24'hE00000,
                             24'hC00000, 24'hA00000, 24'h800000, 24'h800000, 24'h800000};
   localparam logic [23:0] RND_POS = 24'd1;
   localparam logic [23:0] RND_NEG = 24'd0;
`else
   logic [23:0] xpos[10] = '{24'h0FFFFF, 24'h1FFFFF, 24'h2FFFFF, 24'h3FFFFF, 24'h4FFFFF,
                             24'h5FFFFF, 24'h6FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
   logic [23:0] xneg[10] = '{24'h5FFFFF, 24'h3FFFFF, 24'h1FFFFF, 24'hFFFFFF, 24'hDFFFFF,
                             24'hBFFFFF, 24'h9FFFFF, 24'h800000, 24'h800000, 24'h800000};
   localparam logic [23:0] RND_POS = 24'd0;
   localparam logic [23:0] RND_NEG = 24'hFFFFFF;
`endif

   initial begin
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      idle(3);
      reset = 1'b0;
      check("reset_out_valid", {47'd0, out_valid}, 48'd0);
      check("reset_out_data", out_data, 48'd0);
      check("reset_primed", {47'd0, primed}, 48'd0);
      mon_last = '0;
      mon_en   = 1'b1;

      // Alternating ramp on ch0 with ch1 held at 800, back to back.
      for (int i = 0; i < 9; i++)
         send(24'(ramp[i]), 24'd800, 24'(rexp[i]), 24'(r1exp[i]), i >= 7);
      idle(2);

      // Same ramp with 3-cycle gaps.
      do_clear(1'b0, 24'd0);
      for (int i = 0; i < 9; i++) begin
         send(24'(ramp[i]), 24'd0, 24'(rexp[i]), 24'd0, i >= 7);
         idle(3);
      end

      // Extremes: full positive window, then full negative window without clear.
      do_clear(1'b0, 24'd0);
      for (int i = 0; i < 10; i++) send(24'h7FFFFF, 24'd0, xpos[i], 24'd0, i >= 7);
      for (int i = 0; i < 10; i++) send(24'h800000, 24'd0, xneg[i], 24'd0, 1'b1);
      idle(2);

      // Clear mid-stream with a sample that must be dropped.
      do_clear(1'b0, 24'd0);
      for (int i = 0; i < 5; i++) send(24'(ramp[i]), 24'd0, 24'(rexp[i]), 24'd0, 1'b0);
      idle(1);
      do_clear(1'b1, 24'd99);
      send(24'd16, 24'd0, 24'd2, 24'd0, 1'b0);
      for (int i = 0; i < 7; i++) send(24'd0, 24'd0, 24'd2, 24'd0, i == 6);
      send(24'd0, 24'd0, 24'd0, 24'd0, 1'b1);
      idle(2);

      // Rounding behaviour near zero.
      do_clear(1'b0, 24'd0);
      send(24'd4, 24'd0, RND_POS, 24'd0, 1'b0);
      send(24'd0, 24'd0, RND_POS, 24'd0, 1'b0);
      do_clear(1'b0, 24'd0);
      send(24'hFFFFFC, 24'd0, RND_NEG, 24'd0, 1'b0);
      idle(3);

      check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog time limit reached, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/moving_average_filter.md
# moving_average_filter

Parametrised multi-channel boxcar (moving-average) FIR filter for the audio sample path. Each channel keeps its own circular window of the last 2^LOG2_DEPTH samples and a running-sum accumulator, and outputs the window mean. Accumulation is at full precision, with no pre-divide before the sum. It replaces the fixed 24-bit, depth-8, single-channel buffer-plus-accumulator filter and adds per-sample valid qualification, a window-primed flag, a synchronous flush and optional rounding.

## Interface
- DATA_W, 24, signed sample width per channel
- LOG2_DEPTH, 3, log2 of window length; legal range 1..8 (window 2..256)
- CHANNELS, 2, number of independent channels, packed channel 0 in LSBs
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of all windows/accumulators, same effect as reset
- in_valid  in  1  in_data carries one new sample per channel this cycle
- in_data  in  CHANNELS*DATA_W  signed samples, channel c at [c*DATA_W +: DATA_W]
- out_valid  out  1  out_data updated this cycle
- out_data  out  CHANNELS*DATA_W  signed window means, same packing
- primed  out  1  window holds 2^LOG2_DEPTH real samples (mean is over a full window)

## Operation
- Per channel: circular buffer of 2^LOG2_DEPTH x DATA_W words, shared write pointer wr_ptr (LOG2_DEPTH bits), shared fill counter fill (LOG2_DEPTH+1 bits, saturates at 2^LOG2_DEPTH).
- Accumulator acc per channel, signed, DATA_W+LOG2_DEPTH bits; cannot overflow for any input sequence.
- On an accepted sample (in_valid=1, reset=0, clear=0), per channel:
  - oldest = buf[wr_ptr] if fill == 2^LOG2_DEPTH, else 0. Unfilled slots count as zero, so buffer memory is never cleared.
  - acc <= acc + sext(x) - sext(oldest); buf[wr_ptr] <= x.
  - wr_ptr <= wr_ptr+1, wrapping modulo 2^LOG2_DEPTH; fill <= min(fill+1, 2^LOG2_DEPTH).
- Mean = acc >>> LOG2_DEPTH (arithmetic), low DATA_W bits; the result is always in DATA_W range.
- During fill, the output is sum/2^LOG2_DEPTH (zero-padded window), not sum/fill.
- in_valid=0: no state changes; out_data holds; out_valid=0.
- No backpressure; every valid sample is accepted.

## Timing
- Reset/clear values: out_valid=0, out_data=0, primed=0, acc=0, wr_ptr=0, fill=0. Buffer contents are don't-care.
- reset and clear are equivalent. Either one asserted together with in_valid discards that sample, and out_valid=0 on the next cycle.
- Latency 1: a sample accepted at edge N produces out_valid=1 and out_data at edge N+1. That output includes the sample.
- Back-to-back samples: full throughput, one output per cycle.
- primed rises on the same edge as the output of the 2^LOG2_DEPTH-th sample after reset/clear. It stays high until the next reset/clear.
- Wrap-around: the sample at wr_ptr = 2^LOG2_DEPTH-1 is followed by wr_ptr=0, and that next sample subtracts the word written 2^LOG2_DEPTH samples earlier.

## Configuration
- MAF_ROUND_EN defined: mean = (acc + 2^(LOG2_DEPTH-1)) >>> LOG2_DEPTH (round half toward +inf). acc gets one guard bit so this addition cannot overflow, and the result is clamped to the DATA_W signed range.
- MAF_ROUND_EN undefined: mean = acc >>> LOG2_DEPTH (truncation toward -inf), with no extra adder.

## Test plan
Defaults: DATA_W=24, LOG2_DEPTH=3, CHANNELS=2, MAF_ROUND_EN undefined unless stated.
- Alternating ramp on ch0: 8,-16,24,-32,40,-48,56,-64 then 72, back to back. Required ch0 outputs: 1,-1,2,-2,3,-3,4,-4,4. primed rises with the -4 output; each output arrives 1 cycle after its sample.
- Channel independence: ch1 held at 800 while ch0 runs the ramp above. Required ch1 outputs: 100,200,...,800, then 800 steady.
- Extremes: 10 samples of 24'h7FFFFF give a final mean of 24'h7FFFFF. Then 10 samples of 24'h800000 give a final mean of 24'h800000, with no wrap.
- Gaps and wrap: the ramp with in_valid low for 3 cycles between samples gives the same output sequence. out_valid=0 during gaps and out_data holds.
- Clear mid-stream: after 5 samples, assert clear together with in_valid (sample 99). Required: outputs and primed go to 0 and the sample is dropped. Next sample 16 gives output 2, and primed stays 0 until 8 more samples.
- Rounding: ch0 gets 4 then 0s. Without the macro: 0, then -4 gives -1. With MAF_ROUND_EN: 4 gives 1, -4 gives 0, and 10 samples of 24'h7FFFFF give 24'h7FFFFF (clamped).
